// File: rtl/lcd_pkg.sv
// Command codes and sequencer state encoding shared by the LCD command path.
package lcd_pkg;

    localparam logic [3:0] CMD_WRITE       = 4'd0;
    localparam logic [3:0] CMD_SHIFT_UP    = 4'd1;
    localparam logic [3:0] CMD_SHIFT_DOWN  = 4'd2;
    localparam logic [3:0] CMD_SHIFT_LEFT  = 4'd3;
    localparam logic [3:0] CMD_SHIFT_RIGHT = 4'd4;
    localparam logic [3:0] CMD_MAX         = 4'd5;
    localparam logic [3:0] CMD_MIN         = 4'd6;
    localparam logic [3:0] CMD_AVG         = 4'd7;
    localparam logic [3:0] CMD_ROTATE_CW   = 4'd8;
    localparam logic [3:0] CMD_ROTATE_CCW  = 4'd9;
    localparam logic [3:0] CMD_MIRROR_X    = 4'd10;
    localparam logic [3:0] CMD_MIRROR_Y    = 4'd11;
    localparam logic [3:0] CMD_LAST        = CMD_MIRROR_Y;

    typedef enum logic [2:0] {
        ST_BOOT      = 3'd0,
        ST_READY     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_IDLE = 3'd3,
        ST_WAIT_DONE = 3'd4
    } seq_state_e;

    function automatic logic cmd_is_legal(input logic [3:0] code);
        return code <= CMD_LAST;
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
module lcd_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    assign head_o   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Buffers host commands and issues them one at a time to the LCD controller,
// following its busy/done handshake and flagging illegal codes and lost acks.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_BOOT      | controller loading its image; wait for busy to drop
// ST_READY     | free to issue the FIFO head once busy is low
// ST_WAIT_ACK  | strobe sent; wait for busy to rise or the ack timer to expire
// ST_WAIT_IDLE | non-Write command running; wait for busy to fall
// ST_WAIT_DONE | Write running; wait for done (or busy falling without it)
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [3:0]       host_cmd_i,
    input  logic             host_valid_i,
    output logic             host_ready_o,
    input  logic             lcd_busy_i,
    input  logic             lcd_done_i,
    output logic [3:0]       lcd_cmd_o,
    output logic             lcd_cmd_valid_o,
    output logic             frame_done_o,
    output logic             illegal_cmd_o,
    output logic             timeout_err_o,
    output logic             idle_o,
    output logic [CNT_W-1:0] issued_cnt_o
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    seq_state_e       state_q, state_d;
    logic [3:0]       lcd_cmd_q, lcd_cmd_d;
    logic             valid_q, valid_d;
    logic             frame_q, frame_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic             idle_q, idle_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [3:0]       fifo_head;
    logic             host_fire;

    assign fifo_pop     = (state_q == ST_READY) && !fifo_empty && !lcd_busy_i;
    assign host_ready_o = !fifo_full || fifo_pop;
    assign host_fire    = host_valid_i && host_ready_o;
    assign fifo_push    = host_fire && cmd_is_legal(host_cmd_i);

    lcd_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (fifo_push),
        .data_i  (host_cmd_i),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        lcd_cmd_d = lcd_cmd_q;
        valid_d   = 1'b0;
        frame_d   = 1'b0;
        timeout_d = 1'b0;
        timer_d   = timer_q;
        cnt_d     = cnt_q;
        illegal_d = host_fire && !cmd_is_legal(host_cmd_i);
        idle_d    = (state_q == ST_READY) && fifo_empty;

        case (state_q)
            ST_BOOT: begin
                if (!lcd_busy_i) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (fifo_pop) begin
                    lcd_cmd_d = fifo_head;
                    valid_d   = 1'b1;
                    timer_d   = TMR_LOAD;
                    state_d   = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // An ack on the final timer cycle still wins over the timeout.
                if (lcd_busy_i) begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = (lcd_cmd_q == CMD_WRITE) ? ST_WAIT_DONE : ST_WAIT_IDLE;
                end else if (timer_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = ST_READY;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            ST_WAIT_IDLE: begin
                if (!lcd_busy_i) begin
                    state_d = ST_READY;
                end
            end
            ST_WAIT_DONE: begin
                if (lcd_done_i) begin
                    frame_d = 1'b1;
                    state_d = ST_READY;
                end else if (!lcd_busy_i) begin
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_BOOT;
            lcd_cmd_q <= '0;
            valid_q   <= 1'b0;
            frame_q   <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            idle_q    <= 1'b0;
            timer_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            lcd_cmd_q <= lcd_cmd_d;
            valid_q   <= valid_d;
            frame_q   <= frame_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            idle_q    <= idle_d;
            timer_q   <= timer_d;
            cnt_q     <= cnt_d;
        end
    end

    assign lcd_cmd_o       = lcd_cmd_q;
    assign lcd_cmd_valid_o = valid_q;
    assign frame_done_o    = frame_q;
    assign illegal_cmd_o   = illegal_q;
    assign timeout_err_o   = timeout_q;
    assign idle_o          = idle_q;
    assign issued_cnt_o    = cnt_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer: the bench plays the LCD controller by hand.
module tb_lcd_cmd_sequencer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  host_cmd;
    logic        host_valid;
    logic        host_ready;
    logic        lcd_busy;
    logic        lcd_done;
    logic [3:0]  lcd_cmd;
    logic        lcd_cmd_valid;
    logic        frame_done;
    logic        illegal_cmd;
    logic        timeout_err;
    logic        idle;
    logic [15:0] issued_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    int cyc = 0;
    int valid_cnt = 0;
    int frame_cnt = 0;
    int illegal_cnt = 0;
    int timeout_cnt = 0;
    int last_valid_cyc = -10;
    bit viol_busy = 0;
    bit viol_space = 0;
    bit saw_14 = 0;

    lcd_cmd_sequencer #(
        .DEPTH       (8),
        .ACK_TIMEOUT (16),
        .CNT_W       (16)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .host_cmd_i      (host_cmd),
        .host_valid_i    (host_valid),
        .host_ready_o    (host_ready),
        .lcd_busy_i      (lcd_busy),
        .lcd_done_i      (lcd_done),
        .lcd_cmd_o       (lcd_cmd),
        .lcd_cmd_valid_o (lcd_cmd_valid),
        .frame_done_o    (frame_done),
        .illegal_cmd_o   (illegal_cmd),
        .timeout_err_o   (timeout_err),
        .idle_o          (idle),
        .issued_cnt_o    (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol monitor, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (lcd_cmd_valid === 1'b1) begin
            valid_cnt++;
            if (lcd_busy === 1'b1) viol_busy = 1;
            if (cyc - last_valid_cyc < 2) viol_space = 1;
            last_valid_cyc = cyc;
        end
        if (lcd_cmd === 4'd14) saw_14 = 1;
        if (frame_done === 1'b1) frame_cnt++;
        if (illegal_cmd === 1'b1) illegal_cnt++;
        if (timeout_err === 1'b1) timeout_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [3:0] code, output bit rdy);
        host_cmd   = code;
        host_valid = 1'b1;
        #1;
        rdy = host_ready;
        @(negedge clk);
        host_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit found, output logic [3:0] code);
        found = 0;
        code  = 4'hF;
        for (int i = 0; i < budget && !found; i++) begin
            if (lcd_cmd_valid === 1'b1) begin
                found = 1;
                code  = lcd_cmd;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic ack_short();
        lcd_busy = 1'b1;
        tick(2);
        lcd_busy = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (lcd_cmd_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", lcd_cmd_valid); else n_pass++;
        n_checks++; if (lcd_cmd !== 4'd0) $display("FAIL reset_cmd got=%0d exp=0", lcd_cmd); else n_pass++;
        n_checks++; if ({frame_done, illegal_cmd, timeout_err} !== 3'b000) $display("FAIL reset_pulses got=%b exp=000", {frame_done, illegal_cmd, timeout_err}); else n_pass++;
        n_checks++; if (issued_cnt !== 16'd0) $display("FAIL reset_cnt got=%0d exp=0", issued_cnt); else n_pass++;
        n_checks++; if (idle !== 1'b0) $display("FAIL reset_idle got=%0b exp=0", idle); else n_pass++;
        n_checks++; if (host_ready !== 1'b1) $display("FAIL reset_ready got=%0b exp=1", host_ready); else n_pass++;
    endtask

    task automatic test_boot();
        bit rdy;
        bit found;
        logic [3:0] code;
        rst_n = 1'b1;
        push(4'd3, rdy);
        push(4'd5, rdy);
        tick(62);
        n_checks++; if (valid_cnt !== 0) $display("FAIL boot_no_issue got=%0d exp=0", valid_cnt); else n_pass++;
        n_checks++; if (idle !== 1'b0) $display("FAIL boot_idle got=%0b exp=0", idle); else n_pass++;
        lcd_busy = 1'b0;
        wait_valid(8, found, code);
        n_checks++; if (!found || code !== 4'd3) $display("FAIL boot_first found=%0b got=%0d exp=3", found, code); else n_pass++;
        lcd_busy = 1'b1;
        tick(4);
        n_checks++; if (valid_cnt !== 1) $display("FAIL boot_hold_busy got=%0d exp=1", valid_cnt); else n_pass++;
        n_checks++; if (issued_cnt !== 16'd1) $display("FAIL boot_cnt1 got=%0d exp=1", issued_cnt); else n_pass++;
        lcd_busy = 1'b0;
        wait_valid(8, found, code);
        n_checks++; if (!found || code !== 4'd5) $display("FAIL boot_second found=%0b got=%0d exp=5", found, code); else n_pass++;
        ack_short();
        tick(3);
        n_checks++; if (issued_cnt !== 16'd2) $display("FAIL boot_cnt2 got=%0d exp=2", issued_cnt); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL boot_idle_end got=%0b exp=1", idle); else n_pass++;
    endtask

    task automatic test_write();
        bit rdy;
        bit found;
        logic [3:0] code;
        int base_frame;
        int base_valid;
        logic [15:0] base_iss;
        base_frame = frame_cnt;
        base_valid = valid_cnt;
        base_iss   = issued_cnt;
        push(4'd0, rdy);
        push(4'd7, rdy);
        wait_valid(6, found, code);
        n_checks++; if (!found || code !== 4'd0) $display("FAIL write_issue found=%0b got=%0d exp=0", found, code); else n_pass++;
        lcd_busy = 1'b1;
        tick(66);
        n_checks++; if (frame_done !== 1'b0) $display("FAIL write_no_early_frame got=%0b exp=0", frame_done); else n_pass++;
        n_checks++; if (valid_cnt !== base_valid + 1) $display("FAIL write_hold got=%0d exp=%0d", valid_cnt, base_valid + 1); else n_pass++;
        lcd_done = 1'b1;
        tick(1);
        n_checks++; if (frame_done !== 1'b1) $display("FAIL write_frame_pulse got=%0b exp=1", frame_done); else n_pass++;
        lcd_done = 1'b0;
        lcd_busy = 1'b0;
        n_checks++; if (valid_cnt !== base_valid + 1) $display("FAIL write_no_issue_busy got=%0d exp=%0d", valid_cnt, base_valid + 1); else n_pass++;
        tick(1);
        n_checks++; if (frame_done !== 1'b0) $display("FAIL write_frame_width got=%0b exp=0", frame_done); else n_pass++;
        wait_valid(4, found, code);
        n_checks++; if (!found || code !== 4'd7) $display("FAIL write_next found=%0b got=%0d exp=7", found, code); else n_pass++;
        ack_short();
        tick(3);
        n_checks++; if (frame_cnt !== base_frame + 1) $display("FAIL write_frame_once got=%0d exp=%0d", frame_cnt, base_frame + 1); else n_pass++;
        n_checks++; if (issued_cnt !== base_iss + 16'd2) $display("FAIL write_cnt got=%0d exp=%0d", issued_cnt, base_iss + 16'd2); else n_pass++;
    endtask

    task automatic test_illegal();
        bit rdy;
        bit found;
        logic [3:0] code;
        int base_ill;
        logic [15:0] base_iss;
        base_ill = illegal_cnt;
        base_iss = issued_cnt;
        push(4'd14, rdy);
        n_checks++; if (rdy !== 1'b1) $display("FAIL illegal_ready got=%0b exp=1", rdy); else n_pass++;
        n_checks++; if (illegal_cmd !== 1'b1) $display("FAIL illegal_pulse got=%0b exp=1", illegal_cmd); else n_pass++;
        push(4'd9, rdy);
        n_checks++; if (illegal_cmd !== 1'b0) $display("FAIL illegal_width got=%0b exp=0", illegal_cmd); else n_pass++;
        wait_valid(6, found, code);
        n_checks++; if (!found || code !== 4'd9) $display("FAIL illegal_next found=%0b got=%0d exp=9", found, code); else n_pass++;
        ack_short();
        tick(3);
        n_checks++; if (issued_cnt !== base_iss + 16'd1) $display("FAIL illegal_cnt got=%0d exp=%0d", issued_cnt, base_iss + 16'd1); else n_pass++;
        n_checks++; if (illegal_cnt !== base_ill + 1) $display("FAIL illegal_once got=%0d exp=%0d", illegal_cnt, base_ill + 1); else n_pass++;
    endtask

    task automatic test_timeout();
        bit rdy;
        bit found;
        logic [3:0] code;
        int base_to;
        logic [15:0] base_iss;
        base_to  = timeout_cnt;
        base_iss = issued_cnt;
        push(4'd2, rdy);
        push(4'd4, rdy);
        wait_valid(6, found, code);
        n_checks++; if (!found || code !== 4'd2) $display("FAIL timeout_issue found=%0b got=%0d exp=2", found, code); else n_pass++;
        tick(15);
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL timeout_early got=%0b exp=0", timeout_err); else n_pass++;
        tick(1);
        n_checks++; if (timeout_err !== 1'b1) $display("FAIL timeout_pulse got=%0b exp=1", timeout_err); else n_pass++;
        n_checks++; if (issued_cnt !== base_iss) $display("FAIL timeout_cnt got=%0d exp=%0d", issued_cnt, base_iss); else n_pass++;
        wait_valid(4, found, code);
        n_checks++; if (!found || code !== 4'd4) $display("FAIL timeout_next found=%0b got=%0d exp=4", found, code); else n_pass++;
        ack_short();
        tick(3);
        n_checks++; if (issued_cnt !== base_iss + 16'd1) $display("FAIL timeout_cnt_after got=%0d exp=%0d", issued_cnt, base_iss + 16'd1); else n_pass++;
        n_checks++; if (timeout_cnt !== base_to + 1) $display("FAIL timeout_once got=%0d exp=%0d", timeout_cnt, base_to + 1); else n_pass++;
    endtask

    task automatic test_full();
        bit rdy;
        bit found;
        logic [3:0] code;
        int acc;
        int base_valid;
        acc = 0;
        lcd_busy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push(4'(i), rdy);
            acc += int'(rdy);
        end
        n_checks++; if (acc !== 8) $display("FAIL full_accepted got=%0d exp=8", acc); else n_pass++;
        n_checks++; if (host_ready !== 1'b0) $display("FAIL full_ready got=%0b exp=0", host_ready); else n_pass++;
        push(4'd10, rdy);
        n_checks++; if (rdy !== 1'b0) $display("FAIL full_ninth got=%0b exp=0", rdy); else n_pass++;
        base_valid = valid_cnt;
        lcd_busy = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            wait_valid(8, found, code);
            n_checks++; if (!found || code !== 4'(i)) $display("FAIL full_order_%0d found=%0b got=%0d exp=%0d", i, found, code, i); else n_pass++;
            ack_short();
        end
        tick(6);
        n_checks++; if (valid_cnt !== base_valid + 8) $display("FAIL full_total got=%0d exp=%0d", valid_cnt, base_valid + 8); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL full_idle got=%0b exp=1", idle); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit rdy;
        bit found;
        logic [3:0] code;
        int base_valid;
        push(4'd0, rdy);
        wait_valid(6, found, code);
        n_checks++; if (!found || code !== 4'd0) $display("FAIL rmid_issue found=%0b got=%0d exp=0", found, code); else n_pass++;
        lcd_busy = 1'b1;
        push(4'd5, rdy);
        push(4'd6, rdy);
        push(4'd7, rdy);
        tick(2);
        base_valid = valid_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (issued_cnt !== 16'd0) $display("FAIL rmid_cnt got=%0d exp=0", issued_cnt); else n_pass++;
        n_checks++; if ({lcd_cmd_valid, frame_done, idle} !== 3'b000) $display("FAIL rmid_outs got=%b exp=000", {lcd_cmd_valid, frame_done, idle}); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        n_checks++; if (idle !== 1'b0) $display("FAIL rmid_boot got=%0b exp=0", idle); else n_pass++;
        lcd_busy = 1'b0;
        tick(10);
        n_checks++; if (valid_cnt !== base_valid) $display("FAIL rmid_stale got=%0d exp=%0d", valid_cnt, base_valid); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL rmid_empty got=%0b exp=1", idle); else n_pass++;
    endtask

    task automatic test_protocol();
        n_checks++; if (viol_busy !== 1'b0) $display("FAIL proto_issue_busy got=%0b exp=0", viol_busy); else n_pass++;
        n_checks++; if (viol_space !== 1'b0) $display("FAIL proto_spacing got=%0b exp=0", viol_space); else n_pass++;
        n_checks++; if (saw_14 !== 1'b0) $display("FAIL proto_cmd14 got=%0b exp=0", saw_14); else n_pass++;
    endtask

    initial begin
        rst_n      = 1'b1;
        host_cmd   = 4'd0;
        host_valid = 1'b0;
        lcd_busy   = 1'b1;
        lcd_done   = 1'b0;
        #1;
        rst_n = 1'b0;
        tick(3);
        test_reset();
        test_boot();
        test_write();
        test_illegal();
        test_timeout();
        test_full();
        test_reset_mid();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
